p2_mem_read: RTL and testbench
==============================

Name: p2_mem_read

Overview:
- Counter/addresser that reads the pooling-2 output memory (16 entries) back out to feed the fully-connected layer.
- Sweeps all P2 addresses once per FC output neuron ("pass"), NUM_PASSES times in total.
- Generates a matching weight-memory address for every read.
- Delays the issue strobe by the memory read latency so downstream sees valid/first/last flags aligned with the returned data.
- Reads from the same memory that the P2 write counter fills; starts once that write side reports done.

Parameters:
- ADDR_W, 4: P2 memory address width.
- DEPTH, 16: P2 entries per pass. Must equal 2**ADDR_W.
- PASS_W, 4: width of the pass index.
- NUM_PASSES, 10: number of FC neurons, i.e. full sweeps of P2 memory. Range 1..2**PASS_W.
- RD_LAT, 1: P2/weight memory read latency in cycles. Range 1..3.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a full read sequence (tie to the P2 write done rising edge)
- enable  in  1  issue permission; low stalls address generation
- addr0  out  ADDR_W  P2 memory read address
- pass_idx  out  PASS_W  current pass (FC neuron) being issued
- waddr  out  ADDR_W+PASS_W  weight address = {pass_idx, addr0}
- data_valid  out  1  P2/weight data on the memory outputs is valid this cycle
- data_first  out  1  with data_valid: element at address 0 of its pass
- data_last  out  1  with data_valid: element at address DEPTH-1 of its pass
- data_pass  out  PASS_W  pass index belonging to the current data_valid
- busy  out  1  high in READ or DRAIN
- done  out  1  sticky; full sequence complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: all outputs are 0, state is IDLE, and the delay pipeline is cleared. Reset mid-operation aborts immediately; no data_valid appears after it.
- States:
  - IDLE: waits for start, then goes to READ with addr0=0 and pass_idx=0.
  - READ: each cycle with enable=1 issues (addr0, pass_idx) and pushes a 1 into the valid pipeline.
  - DRAIN: waits RD_LAT cycles, then goes to DONE.
  - DONE: done=1; start restarts the sequence.
- Issue in READ:
  - A cycle with enable=1 is an issue cycle. After the issue, addr0 increments.
  - When addr0=DEPTH-1 is issued: addr0 wraps to 0 and pass_idx increments.
  - When addr0=DEPTH-1 and pass_idx=NUM_PASSES-1 are issued: go to DRAIN. addr0 and pass_idx hold their final values.
- Stall: enable=0 in READ holds addr0/pass_idx and pushes a 0 into the pipeline. The pipeline always shifts; memory is not stallable.
- Delay pipeline: depth RD_LAT, carrying {issue, addr0==0, addr0==DEPTH-1, pass_idx}.
  - data_valid/first/last/data_pass are the pipeline outputs, registered.
  - data_first and data_last are 0 whenever data_valid=0.
- Timing: start sampled at edge k.
  - First issue occurs in the cycle after edge k.
  - With enable held high, data_valid is high for exactly NUM_PASSES*DEPTH consecutive cycles, starting RD_LAT cycles after the first issue.
  - done rises at edge k+NUM_PASSES*DEPTH+RD_LAT+1.
- busy: 1 in READ and DRAIN, otherwise 0.
- done: 0 in IDLE/READ/DRAIN. Rises on entry to DONE and holds until reset or restart.
- start handling:
  - start while busy is ignored.
  - start in DONE clears done next cycle and restarts from addr0=0, pass_idx=0.
  - start and reset together: reset wins.
- enable outside READ has no effect.
- waddr is pure concatenation; no arithmetic carry is possible.

Optional Feature:
- Macro P2_RD_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits).
  - Counts cycles in READ with enable=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by an accepted start; holds value in DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then start at edge 0 with enable=1 and defaults -> addr0 sequence 0..15 repeated 10 times; pass_idx steps 0..9; waddr 0..159; 160 data_valid cycles starting cycle 2; done=1 from edge 162.
- Same run with enable=0 for 3 cycles while addr0=5, pass 2 -> addr0 holds 5; data_valid drops exactly 3 cycles (aligned RD_LAT later); done delayed to edge 165. With P2_RD_STALL_CNT_EN, stall_cnt=3.
- RD_LAT=3 -> first data_valid 3 cycles after first issue; data_first with data_pass=0; data_last on 160th valid with data_pass=9; done at edge 164.
- start pulsed while busy at pass 4 -> ignored; total valid count stays 160; done timing unchanged.
- reset asserted mid-pass 6 -> next cycle all outputs 0, no further data_valid. A new start yields a clean full 160-read sequence.
- start in DONE -> done=0 next cycle and sequence repeats identically. NUM_PASSES=1 -> 16 valids, first/last on valids 1 and 16.

Source files
------------

// File: rtl/p2_mem_read.sv
// Sweeps the P2 memory once per FC neuron and tags the returned data. Build option P2_RD_STALL_CNT_EN adds stall_cnt.
// Latency: data_valid/first/last/data_pass trail each issue by RD_LAT cycles; done rises RD_LAT+1 cycles after the last issue.
// Backpressure: enable=0 holds the address; the read pipeline keeps shifting and carries a bubble.
module p2_mem_read #(
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int PASS_W     = 4,
    parameter int NUM_PASSES = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     enable,
    output logic [ADDR_W-1:0]        addr0,
    output logic [PASS_W-1:0]        pass_idx,
    output logic [ADDR_W+PASS_W-1:0] waddr,
    output logic                     data_valid,
    output logic                     data_first,
    output logic                     data_last,
    output logic [PASS_W-1:0]        data_pass,
    output logic                     busy,
    output logic                     done
`ifdef P2_RD_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
    localparam logic [1:0]        DRAIN_END = 2'(RD_LAT);

    state_t state_q, state_d;
    logic   issue;
    logic   restart;
    logic [1:0] drain_q;

    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] first_p;
    logic [RD_LAT-1:0] last_p;
    logic [PASS_W-1:0] pass_p [RD_LAT];

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = READ;
                    restart = 1'b1;
                end
            end
            READ: begin
                if (enable) begin
                    issue = 1'b1;
                    if (addr0 == ADDR_LAST && pass_idx == PASS_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // one extra cycle beyond the read latency so done follows the last data beat
                if (drain_q == DRAIN_END) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr0    <= '0;
            pass_idx <= '0;
            drain_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
            if (restart) begin
                addr0    <= '0;
                pass_idx <= '0;
            end else if (issue && state_d == READ) begin
                // final issue leaves addr0/pass_idx parked on their last values
                if (addr0 == ADDR_LAST) begin
                    addr0    <= '0;
                    pass_idx <= pass_idx + PASS_W'(1);
                end else begin
                    addr0 <= addr0 + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pass_p[i] <= '0;
            end
        end else begin
            vld_p[0]   <= issue;
            first_p[0] <= issue && (addr0 == '0);
            last_p[0]  <= issue && (addr0 == ADDR_LAST);
            pass_p[0]  <= issue ? pass_idx : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]   <= vld_p[i-1];
                first_p[i] <= first_p[i-1];
                last_p[i]  <= last_p[i-1];
                pass_p[i]  <= pass_p[i-1];
            end
        end
    end

`ifdef P2_RD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            stall_cnt <= '0;
        end else if (state_q == READ && !enable && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign waddr      = {pass_idx, addr0};
    assign data_valid = vld_p[RD_LAT-1];
    assign data_first = first_p[RD_LAT-1];
    assign data_last  = last_p[RD_LAT-1];
    assign data_pass  = pass_p[RD_LAT-1];
    assign busy       = (state_q == READ) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_p2_mem_read.sv
// Bench for p2_mem_read: three instances (default, RD_LAT=3, NUM_PASSES=1) share stimulus
// and are compared every cycle against a linear-index reference model.
module tb_p2_mem_read;

    logic clk = 1'b0;
    logic reset, start, enable;
    always #5 clk = ~clk;

    logic [3:0] o_addr0 [3];
    logic [3:0] o_pass  [3];
    logic [7:0] o_waddr [3];
    logic       o_vld   [3];
    logic       o_first [3];
    logic       o_last  [3];
    logic [3:0] o_dpass [3];
    logic       o_busy  [3];
    logic       o_done  [3];
`ifdef P2_RD_STALL_CNT_EN
    logic [15:0] o_stall [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        p2_mem_read #(
            .NUM_PASSES(g == 2 ? 1 : 10),
            .RD_LAT    (g == 1 ? 3 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .enable    (enable),
            .addr0     (o_addr0[g]),
            .pass_idx  (o_pass[g]),
            .waddr     (o_waddr[g]),
            .data_valid(o_vld[g]),
            .data_first(o_first[g]),
            .data_last (o_last[g]),
            .data_pass (o_dpass[g]),
            .busy      (o_busy[g]),
            .done      (o_done[g])
`ifdef P2_RD_STALL_CNT_EN
            ,
            .stall_cnt (o_stall[g])
`endif
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 0;

    function automatic int np_of(int i);
        return (i == 2) ? 1 : 10;
    endfunction
    function automatic int lat_of(int i);
        return (i == 1) ? 3 : 1;
    endfunction

    // Reference model: m_n counts issues so far; an issue's address is n%16, its pass n/16.
    logic s_reset = 1'b1, s_start = 1'b0, s_en = 1'b0;
    int m_n [3];
    bit m_run [3];
    int m_drain [3];
    bit m_done [3];
    int m_hist [3][4];
    int m_stall [3];

    initial forever begin
        @(posedge clk);
        s_reset = reset;
        s_start = start;
        s_en    = enable;
        cyc++;
    end

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (s_reset) begin
                m_n[i] = 0; m_run[i] = 0; m_drain[i] = -1; m_done[i] = 0; m_stall[i] = 0;
                for (int j = 0; j < 4; j++) m_hist[i][j] = -1;
            end else begin
                for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = (m_run[i] && s_en) ? m_n[i] : -1;
                if (m_run[i]) begin
                    if (s_en) begin
                        m_n[i]++;
                        if (m_n[i] == np_of(i) * 16) begin
                            m_run[i] = 0;
                            m_drain[i] = 0;
                        end
                    end else if (m_stall[i] < 65535) begin
                        m_stall[i]++;
                    end
                end else if (m_drain[i] >= 0) begin
                    m_drain[i]++;
                    if (m_drain[i] == lat_of(i) + 1) begin
                        m_done[i] = 1;
                        m_drain[i] = -1;
                    end
                end else if (s_start) begin
                    m_run[i] = 1; m_n[i] = 0; m_done[i] = 0; m_stall[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [24:0] exp_vec(int i);
        int a, p, h, dp;
        logic v, f, l, b;
        if (m_run[i]) begin
            a = m_n[i] % 16; p = m_n[i] / 16;
        end else if (m_n[i] == np_of(i) * 16) begin
            a = 15; p = np_of(i) - 1;
        end else begin
            a = 0; p = 0;
        end
        h  = m_hist[i][lat_of(i) - 1];
        v  = (h >= 0);
        f  = v && (h % 16 == 0);
        l  = v && (h % 16 == 15);
        dp = v ? h / 16 : 0;
        b  = m_run[i] || (m_drain[i] >= 0);
        return {4'(a), 4'(p), 8'(p * 16 + a), v, f, l, 4'(dp), b, m_done[i]};
    endfunction

    function automatic logic [24:0] obs_vec(int i);
        return {o_addr0[i], o_pass[i], o_waddr[i], o_vld[i], o_first[i], o_last[i],
                o_dpass[i], o_busy[i], o_done[i]};
    endfunction

    initial forever begin
        @(negedge clk);
        model_step();
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL cycle_outputs inst%0d cyc=%0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
                end
`ifdef P2_RD_STALL_CNT_EN
                checks++;
                if (o_stall[i] !== 16'(m_stall[i])) begin
                    errors++;
                    $display("FAIL stall_cnt inst%0d cyc=%0d: got %0d want %0d", i, cyc, o_stall[i], m_stall[i]);
                end
`endif
            end
        end
    end

    // Per-run observations gathered by run_seq
    int vcnt [3], fcnt [3], lcnt [3], done_at [3], first_at [3], first_dp [3], last_dp [3];
    logic done0 [3];

    task automatic run_seq(input int mode);
        int k, stall_left;
        bit stalled, pulsed, all_done;
        stalled = 0; pulsed = 0; stall_left = 0;
        for (int i = 0; i < 3; i++) begin
            vcnt[i] = 0; fcnt[i] = 0; lcnt[i] = 0; done_at[i] = -1;
            first_at[i] = -1; first_dp[i] = -1; last_dp[i] = -1; done0[i] = 1'b1;
        end
        @(negedge clk); start = 1'b1; enable = 1'b1;
        @(negedge clk); start = 1'b0; k = cyc;
        for (int t = 0; t < 1200; t++) begin
            all_done = 1;
            for (int i = 0; i < 3; i++) begin
                if (t == 0) done0[i] = o_done[i];
                if (o_vld[i]) begin
                    if (vcnt[i] == 0) begin
                        first_at[i] = cyc - k;
                        first_dp[i] = int'(o_dpass[i]);
                    end
                    vcnt[i]++;
                    last_dp[i] = int'(o_dpass[i]);
                end
                fcnt[i] += int'(o_first[i]);
                lcnt[i] += int'(o_last[i]);
                if (o_done[i] && done_at[i] < 0) done_at[i] = cyc - k;
                if (done_at[i] < 0) all_done = 0;
            end
            if (all_done) break;
            start = 1'b0; enable = 1'b1;
            case (mode)
                1: begin
                    if (!stalled && o_addr0[0] == 4'd5 && o_pass[0] == 4'd2) begin
                        stalled = 1; stall_left = 3;
                    end
                    if (stall_left > 0) begin
                        enable = 1'b0; stall_left--;
                    end
                end
                2: enable = ($urandom_range(0, 3) != 0);
                3: if (!pulsed && o_pass[0] == 4'd4 && o_addr0[0] == 4'd7) begin
                    pulsed = 1; start = 1'b1;
                end
                default: ;
            endcase
            @(negedge clk);
        end
        start = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== 25'd0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: got %h want 0", i, obs_vec(i));
            end
        end
        start = 1'b1; enable = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_wins_start inst%0d: busy got %b want 0", i, o_busy[i]);
            end
        end
    endtask

    task automatic test_full_run(input string nm);
        run_seq(0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vcnt[i] !== np_of(i) * 16) begin
                errors++; $display("FAIL %s_vcount inst%0d: got %0d want %0d", nm, i, vcnt[i], np_of(i) * 16);
            end
            checks++;
            if (done_at[i] !== np_of(i) * 16 + lat_of(i) + 1) begin
                errors++; $display("FAIL %s_done_edge inst%0d: got %0d want %0d", nm, i, done_at[i], np_of(i) * 16 + lat_of(i) + 1);
            end
            checks++;
            if (first_at[i] !== lat_of(i)) begin
                errors++; $display("FAIL %s_first_valid inst%0d: got %0d want %0d", nm, i, first_at[i], lat_of(i));
            end
            checks++;
            if (fcnt[i] !== np_of(i) || lcnt[i] !== np_of(i)) begin
                errors++; $display("FAIL %s_first_last inst%0d: got %0d/%0d want %0d", nm, i, fcnt[i], lcnt[i], np_of(i));
            end
            checks++;
            if (first_dp[i] !== 0 || last_dp[i] !== np_of(i) - 1) begin
                errors++; $display("FAIL %s_data_pass inst%0d: got %0d..%0d want 0..%0d", nm, i, first_dp[i], last_dp[i], np_of(i) - 1);
            end
        end
    endtask

    task automatic test_stall();
        run_seq(1);
        checks++;
        if (done_at[0] !== 165) begin
            errors++; $display("FAIL stall_done_edge: got %0d want 165", done_at[0]);
        end
        checks++;
        if (done_at[1] !== 167) begin
            errors++; $display("FAIL stall_done_edge_lat3: got %0d want 167", done_at[1]);
        end
        checks++;
        if (vcnt[0] !== 160) begin
            errors++; $display("FAIL stall_vcount: got %0d want 160", vcnt[0]);
        end
`ifdef P2_RD_STALL_CNT_EN
        checks++;
        if (o_stall[0] !== 16'd3) begin
            errors++; $display("FAIL stall_cnt_final: got %0d want 3", o_stall[0]);
        end
`endif
    endtask

    task automatic test_random();
        run_seq(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vcnt[i] !== np_of(i) * 16 || done_at[i] < 0) begin
                errors++; $display("FAIL random_vcount inst%0d: got %0d (done_at %0d) want %0d", i, vcnt[i], done_at[i], np_of(i) * 16);
            end
        end
    endtask

    task automatic test_start_busy();
        run_seq(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (vcnt[i] !== 160 || done_at[i] !== 161 + lat_of(i)) begin
                errors++; $display("FAIL start_while_busy inst%0d: got %0d valids done %0d want 160 done %0d", i, vcnt[i], done_at[i], 161 + lat_of(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, vc;
        @(negedge clk); start = 1'b1; enable = 1'b1;
        @(negedge clk); start = 1'b0;
        for (t = 0; t < 400 && !(o_pass[0] == 4'd6 && o_addr0[0] == 4'd3); t++) @(negedge clk);
        checks++;
        if (t >= 400) begin
            errors++; $display("FAIL reset_mid_reach_pass6: got timeout want pass 6");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== 25'd0) begin
                errors++; $display("FAIL reset_mid_outputs inst%0d: got %h want 0", i, obs_vec(i));
            end
        end
        vc = 0;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) vc += int'(o_vld[i]);
        end
        checks++;
        if (vc !== 0) begin
            errors++; $display("FAIL reset_mid_no_valid: got %0d want 0", vc);
        end
        test_full_run("after_reset");
    endtask

    task automatic test_restart();
        test_full_run("restart");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done0[i] !== 1'b0) begin
                errors++; $display("FAIL restart_done_clear inst%0d: got %b want 0", i, done0[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run("full");
        test_stall();
        test_random();
        test_start_busy();
        test_reset_mid();
        test_restart();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
